// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator for the register RAM.
// Define MEM_ACCESS_BYTE_STORE_EN to enable partial-byte stores via read-modify-write.
module mem_access_unit #(
    parameter int DataWidth = 16,
    parameter int NumRegs   = 8,
    parameter int AddrWidth = $clog2(NumRegs),
    parameter int NumBytes  = DataWidth / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [AddrWidth-1:0] reqAddr,
    input  logic [DataWidth-1:0] reqData,
    input  logic [NumBytes-1:0]  reqByteEn,
    output logic                 respValid,
    input  logic                 respReady,
    output logic [DataWidth-1:0] respData,
    output logic                 respErr,
    output logic                 ramWriteEnable,
    output logic [AddrWidth-1:0] ramWriteAddr,
    output logic [DataWidth-1:0] ramWriteData,
    output logic [AddrWidth-1:0] ramReadAddr,
    input  logic [DataWidth-1:0] ramReadData
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]           state_q, state_d;
    logic                 write_q, write_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [DataWidth-1:0] resp_data_q, resp_data_d;
    logic                 resp_err_q, resp_err_d;
    logic                 in_range;
    logic                 full_word;

    assign in_range = {1'b0, addr_q} < (AddrWidth+1)'(NumRegs);

`ifdef MEM_ACCESS_BYTE_STORE_EN
    localparam logic [1:0] MERGE = 2'd2;

    logic [NumBytes-1:0]  be_q, be_d;
    logic [DataWidth-1:0] merged;

    always_comb begin
        merged = ramReadData;
        for (int b = 0; b < NumBytes; b++)
            if (be_q[b]) merged[8*b +: 8] = data_q[8*b +: 8];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) be_q <= '0;
        else     be_q <= be_d;

    assign be_d           = (state_q == IDLE && reqValid) ? reqByteEn : be_q;
    assign full_word      = be_q == '1;
    // the merged word is already parked in resp_data_q during MERGE
    assign ramWriteData   = (state_q == MERGE) ? resp_data_q : data_q;
    assign ramWriteEnable = (state_q == EXEC && write_q && in_range && full_word) || state_q == MERGE;
`else
    logic unused_be;

    assign unused_be      = ^reqByteEn;
    assign full_word      = 1'b1;
    assign ramWriteData   = data_q;
    assign ramWriteEnable = state_q == EXEC && write_q && in_range && full_word;
`endif

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            IDLE: if (reqValid) begin
                write_d = reqWrite;
                addr_d  = reqAddr;
                data_d  = reqData;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = RESP;
                if (!in_range) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end
                else if (!write_q) resp_data_d = ramReadData;
`ifdef MEM_ACCESS_BYTE_STORE_EN
                else if (be_q == '0) resp_data_d = ramReadData;
                else if (!full_word) begin
                    resp_data_d = merged;
                    state_d     = MERGE;
                end
`endif
                else resp_data_d = data_q;
            end
`ifdef MEM_ACCESS_BYTE_STORE_EN
            MERGE: state_d = RESP;
`endif
            RESP: if (respReady) begin
                state_d    = IDLE;
                resp_err_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end
        else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end

    assign reqReady     = state_q == IDLE;
    assign respValid    = state_q == RESP;
    assign respData     = resp_data_q;
    assign respErr      = resp_err_q;
    assign ramWriteAddr = addr_q;
    assign ramReadAddr  = addr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus random load/store traffic against a word-array reference model.
// Expectations follow MEM_ACCESS_BYTE_STORE_EN the same way the design build does.
module tb_mem_access_unit;
    localparam int DW = 16;
    localparam int NR = 6;
    localparam int AW = $clog2(NR);
    localparam int NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          reqValid = 1'b0, reqReady, reqWrite = 1'b0;
    logic [AW-1:0] reqAddr = '0;
    logic [DW-1:0] reqData = '0;
    logic [NB-1:0] reqByteEn = '0;
    logic          respValid, respReady = 1'b0, respErr;
    logic [DW-1:0] respData;
    logic          ramWriteEnable;
    logic [AW-1:0] ramWriteAddr, ramReadAddr;
    logic [DW-1:0] ramWriteData, ramReadData;

    logic [DW-1:0] ram     [NR] = '{default: '0};
    logic [DW-1:0] ref_mem [NR] = '{default: '0};
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DataWidth(DW), .NumRegs(NR)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqData(reqData), .reqByteEn(reqByteEn),
        .respValid(respValid), .respReady(respReady), .respData(respData), .respErr(respErr),
        .ramWriteEnable(ramWriteEnable), .ramWriteAddr(ramWriteAddr), .ramWriteData(ramWriteData),
        .ramReadAddr(ramReadAddr), .ramReadData(ramReadData)
    );

    // RAM stand-in: synchronous write, combinational read
    assign ramReadData = (int'(ramReadAddr) < NR) ? ram[ramReadAddr] : '0;
    always @(posedge clk)
        if (ramWriteEnable && int'(ramWriteAddr) < NR) ram[ramWriteAddr] <= ramWriteData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_req();
        reqValid  = 1'($urandom_range(0, 1));
        reqWrite  = 1'($urandom);
        reqAddr   = AW'($urandom);
        reqData   = DW'($urandom);
        reqByteEn = NB'($urandom);
    endtask

    // one request from the IDLE negedge through handshake; hold = cycles respReady stays low
    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NB-1:0] be, input int hold);
        logic [DW-1:0] exp_d, held;
        logic          exp_e;
        logic [AW-1:0] we_addr;
        int            exp_lat, exp_we, lat, we_cnt;
        exp_e   = int'(a) >= NR;
        exp_we  = 0;
        exp_lat = 2;
        exp_d   = '0;
        if (!exp_e && !w) exp_d = ref_mem[a];
        else if (!exp_e) begin
`ifdef MEM_ACCESS_BYTE_STORE_EN
            if (be == '0) exp_d = ref_mem[a];
            else begin
                for (int i = 0; i < NB; i++) exp_d[8*i +: 8] = be[i] ? d[8*i +: 8] : ref_mem[a][8*i +: 8];
                exp_we = 1;
                if (be != '1) exp_lat = 3;
            end
`else
            exp_d  = d;
            exp_we = 1;
`endif
            ref_mem[a] = exp_d;
        end
        chk("req_ready_idle", reqReady, 1);
        reqValid = 1'b1; reqWrite = w; reqAddr = a; reqData = d; reqByteEn = be;
        @(posedge clk);
        lat = 0; we_cnt = 0; we_addr = '0;
        do begin
            @(negedge clk);
            lat++;
            scramble_req();
            if (ramWriteEnable) begin we_cnt++; we_addr = ramWriteAddr; end
        end while (!respValid && lat < 8);
        chk("latency", lat, exp_lat);
        chk("resp_data", respData, exp_d);
        chk("resp_err", respErr, exp_e);
        chk("we_pulses", we_cnt, exp_we);
        if (exp_we != 0) chk("we_addr", we_addr, a);
        held = respData;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            scramble_req();
            chk("hold_valid", respValid, 1);
            chk("hold_data", respData, held);
            chk("hold_not_ready", reqReady, 0);
        end
        reqValid  = 1'b0;
        respReady = 1'b1;
        @(negedge clk);
        respReady = 1'b0;
        chk("valid_cleared", respValid, 0);
        chk("err_cleared", respErr, 0);
        chk("ready_back", reqReady, 1);
        if (!exp_e && w) chk("ram_word", ram[a], ref_mem[a]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", reqReady, 1);
        chk("rst_resp_valid", respValid, 0);
        chk("rst_resp_err", respErr, 0);
        chk("rst_resp_data", respData, 0);
        chk("rst_we", ramWriteEnable, 0);
        chk("rst_wdata", ramWriteData, 0);
        chk("rst_waddr", ramWriteAddr, 0);
        chk("rst_raddr", ramReadAddr, 0);
        rst = 1'b0;
        @(negedge clk);

        txn(1'b1, 3'd3, 16'hBEEF, 2'b11, 0);
        txn(1'b0, 3'd3, 16'h0000, 2'b00, 0);
        txn(1'b0, 3'd3, 16'h1111, 2'b11, 5);
        txn(1'b1, 3'd7, 16'h5555, 2'b11, 0);
        txn(1'b0, 3'd7, 16'h0000, 2'b11, 1);
        txn(1'b1, 3'd2, 16'h1234, 2'b11, 0);
        txn(1'b1, 3'd2, 16'hABCD, 2'b01, 0);
        txn(1'b0, 3'd2, 16'h0000, 2'b00, 0);
        txn(1'b1, 3'd4, 16'h7777, 2'b00, 0);

        // reset during the EXEC cycle of a full-word store to addr 1
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 3'd1; reqData = 16'h5A5A; reqByteEn = 2'b11;
        @(posedge clk);
        #2;
        reqValid = 1'b0;
        chk("exec_we_before_rst", ramWriteEnable, 1);
        rst = 1'b1;
        #1;
        chk("we_drop_on_rst", ramWriteEnable, 0);
        chk("ready_on_rst", reqReady, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("ram1_untouched", ram[1], 0);
        chk("no_resp_after_rst", respValid, 0);
        chk("ready_after_rst", reqReady, 1);
        txn(1'b0, 3'd1, 16'h0000, 2'b00, 0);

        for (int n = 0; n < 40; n++)
            txn(1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom), NB'($urandom), $urandom_range(0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the single-write-port / combinational-read-port register RAM.
- Accepts one load or store at a time from the CPU core over a valid/ready request channel, and drives the RAM's write and read ports.
- Returns each result on a valid/ready response channel.
- Sits between the core's execute stage and the RAM instance. It is the only block driving the RAM port signals.

Parameters:
- DataWidth, 16, word width. Must be a multiple of 8.
- NumRegs, 8, number of RAM words. Need not be a power of two.
- AddrWidth, $clog2(NumRegs), address width.
- NumBytes, DataWidth/8, number of byte lanes.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- reqValid  input  1  request present
- reqReady  output  1  unit can accept a request
- reqWrite  input  1  1 = store, 0 = load
- reqAddr  input  AddrWidth  word address
- reqData  input  DataWidth  store data
- reqByteEn  input  NumBytes  byte lane enables for stores
- respValid  output  1  response present
- respReady  input  1  core accepts response
- respData  output  DataWidth  load data; for a store, the word now held in RAM
- respErr  output  1  address was out of range (reqAddr >= NumRegs)
- ramWriteEnable  output  1  to RAM writeEnable
- ramWriteAddr  output  AddrWidth  to RAM writeAddr
- ramWriteData  output  DataWidth  to RAM writeData
- ramReadAddr  output  AddrWidth  to RAM readAddr
- ramReadData  input  DataWidth  from RAM readData (combinational)

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - reqReady = 1.
  - respValid, respErr, ramWriteEnable = 0.
  - respData, ramWriteData = 0.
  - ramWriteAddr, ramReadAddr, and the latched address = 0.
- States: IDLE, EXEC, MERGE (macro only), RESP.
- reqReady = 1 only in IDLE.
- Accept: reqValid && reqReady at a rising edge. The unit latches write, addr, data and byteEn, then moves IDLE -> EXEC.
- All RAM port outputs decode from registers only. No combinational path from req* to ram*.
- ramReadAddr and ramWriteAddr always equal the latched address.
- ramWriteData equals the latched data, or the merged word in MERGE.
- EXEC, load:
  - The unit samples ramReadData at the end of EXEC into respData.
  - Next state is RESP.
- EXEC, store, full word (all byteEn set, or macro absent):
  - ramWriteEnable = 1 for exactly this cycle.
  - respData <= latched data.
  - Next state is RESP.
- Out-of-range address:
  - ramWriteEnable is held 0.
  - respData <= 0 and respErr <= 1.
  - The unit still goes to RESP.
- RESP:
  - respValid = 1.
  - respData and respErr are held stable until respReady.
  - On respValid && respReady the unit goes to IDLE and clears respValid and respErr.
  - A new request can be accepted in the cycle after that handshake.
- Latency: accept edge N, respValid high from edge N+2 (N+3 via MERGE). Peak throughput is one request per 3 cycles.
- Ordering and coherence:
  - A store's RAM write commits at the end of EXEC, before its response.
  - A load issued after a store's response always returns the stored data.
- reqValid while not ready: no effect. Request fields may change freely.
- respReady while respValid = 0: ignored.
- Reset mid-operation:
  - The in-flight request is dropped with no response.
  - If reset asserts during EXEC, ramWriteEnable drops to 0 immediately and that RAM write does not occur.

Optional Feature:
- Macro: MEM_ACCESS_BYTE_STORE_EN
- Defined:
  - A store whose byteEn is neither all-ones nor all-zeros becomes a read-modify-write.
  - EXEC reads the RAM word (no write) and goes to MERGE.
  - MERGE writes merged = byteEn lanes from latched data, other lanes from the read word, with ramWriteEnable = 1 for one cycle.
  - respData <= merged. Then RESP.
  - byteEn all-zeros: no RAM write; respData <= current RAM word; goes directly to RESP.
- Not defined:
  - reqByteEn is ignored and every store is a full-word write.
  - The MERGE state does not exist.

Test Plan:
- Reset, then store addr 3 data 16'hBEEF with respReady = 1 -> ramWriteEnable high exactly one cycle with addr 3, respValid at accept+2, respData = 16'hBEEF, respErr = 0.
- Load addr 3 after the previous test -> respData = 16'hBEEF at accept+2. No ramWriteEnable pulse.
- Hold respReady = 0 for 5 cycles on a load -> respValid and respData stable, reqReady = 0 throughout. One-cycle respReady -> IDLE, next request accepted the following cycle.
- NumRegs = 6, store addr 7 then load addr 7 -> no RAM write. Both responses have respErr = 1 and the load's respData = 0.
- Macro on: RAM[2] = 16'h1234, store addr 2 data 16'hABCD byteEn 2'b01 -> respValid at accept+3, RAM[2] = 16'h12CD, respData = 16'h12CD. Macro off, same stimulus -> RAM[2] = 16'hABCD at accept+2.
- Assert rst during EXEC of a store to addr 1 holding 16'h0000 -> ramWriteEnable 0 immediately, RAM[1] still 16'h0000, no response, reqReady = 1 after reset release.
